// File: rtl/pipelined_instruction_decoder_pkg.sv
// pipelined_instruction_decoder_pkg: opcode classes, register codes, enable bit map and FSM states
// Rev 1.0
`default_nettype none
package pipelined_instruction_decoder_pkg;

  typedef enum logic [2:0] {
    LOAD             = 3'd0,
    MOVE             = 3'd1,
    ALU              = 3'd2,
    JUMP             = 3'd3,
    CONDITIONAL_JUMP = 3'd4
  } instruction_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } mul_state_t;

  localparam logic [2:0] C_DST_X0   = 3'd0;
  localparam logic [2:0] C_DST_X1   = 3'd1;
  localparam logic [2:0] C_DST_Y0   = 3'd2;
  localparam logic [2:0] C_DST_Y1   = 3'd3;
  localparam logic [2:0] C_DST_OREG = 3'd4;
  localparam logic [2:0] C_SRC_R    = 3'd4;
  localparam logic [2:0] C_DST_M    = 3'd5;
  localparam logic [2:0] C_DST_I    = 3'd6;
  localparam logic [2:0] C_DST_DM   = 3'd7;

  localparam int C_EN_R    = 4;
  localparam int C_EN_I    = 6;
  localparam int C_EN_OREG = 8;

  localparam logic [2:0] MUL_FUNC  = 3'b111;
  localparam logic [3:0] SRC_LOAD  = 4'd8;
  localparam logic [3:0] SRC_RESET = 4'd10;

  function automatic instruction_t decode_type(input logic [7:0] ir);
    if (!ir[7])      decode_type = LOAD;
    else if (!ir[6]) decode_type = MOVE;
    else if (!ir[5]) decode_type = ALU;
    else if (!ir[4]) decode_type = JUMP;
    else             decode_type = CONDITIONAL_JUMP;
  endfunction

  // Destination code 4 is o_reg, which lives at enable bit 8 rather than bit 4.
  function automatic logic [8:0] dst_enable(input logic [2:0] code);
    dst_enable = '0;
    if (code == C_DST_OREG) dst_enable[C_EN_OREG] = 1'b1;
    else                    dst_enable[code]      = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_instruction_decoder_stall_ctrl.sv
// decode_stall_ctrl: multiply stall sequencer and post-jump squash counter
// Rev 1.0
`default_nettype none
module decode_stall_ctrl
  import pipelined_instruction_decoder_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int JMP_SQUASH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_mul_op,
  input  logic i_jmp_taken,
  output logic o_stall,
  output logic o_final_cycle,
  output logic o_squash_next
);

  localparam logic [3:0] C_LAST = 4'(MUL_LAT - 1);
  localparam logic [1:0] C_SQ   = 2'(JMP_SQUASH);

  mul_state_t r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_sq_cnt;
  logic [3:0] w_cnt_eff;
  logic [1:0] w_sq_eff;

  // The cycle a multiply first appears in ir counts as cnt = 0.
  assign w_cnt_eff     = (r_state == MUL_WAIT) ? r_cnt : 4'd0;
  assign o_stall       = i_mul_op && (w_cnt_eff != C_LAST);
  assign o_final_cycle = ~o_stall;
  // A taken jump squashes the very next load, so its count is used in the same cycle.
  assign w_sq_eff      = i_jmp_taken ? C_SQ : r_sq_cnt;
  assign o_squash_next = (w_sq_eff != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_sq_cnt <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_mul_op && (C_LAST != 4'd0)) begin
            r_state <= MUL_WAIT;
            r_cnt   <= 4'd1;
          end
        end
        MUL_WAIT: begin
          if (r_cnt == C_LAST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
      if (!o_stall && o_squash_next) r_sq_cnt <= w_sq_eff - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder: 8-bit microsequencer decoder with multiply stall, jump squash and bubbles
// Rev 1.0
`default_nettype none
module pipelined_instruction_decoder
  import pipelined_instruction_decoder_pkg::*;
#(
  parameter int MUL_LAT    = 3,
  parameter int JMP_SQUASH = 1,
  parameter int NUM_EN     = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        next_instr,
  input  logic              instr_valid,
  input  logic              zero_flag,
  output logic [7:0]        ir,
  output logic [3:0]        ir_nibble,
  output logic              jmp,
  output logic              jmp_nz,
  output logic              jmp_taken,
  output logic              i_sel,
  output logic              x_sel,
  output logic              y_sel,
  output logic [3:0]        source_sel,
  output logic [NUM_EN-1:0] reg_en,
  output logic              stall
);

  logic [7:0]   r_ir;
  logic         r_bubble;
  instruction_t w_type;
  logic [8:0]   w_en;
  logic [3:0]   w_src;
  logic         w_isel, w_x, w_y, w_jmp, w_jnz, w_jmp_taken;
  logic         w_mul_op, w_stall, w_final, w_squash_next;
  logic [2:0]   w_ld_dst, w_mv_dst, w_mv_src;

  assign w_type   = decode_type(r_ir);
  assign w_ld_dst = r_ir[6:4];
  assign w_mv_dst = r_ir[5:3];
  assign w_mv_src = r_ir[2:0];
  assign w_mul_op = !r_bubble && (w_type == ALU) && (r_ir[2:0] == MUL_FUNC);

  decode_stall_ctrl #(
    .MUL_LAT    (MUL_LAT),
    .JMP_SQUASH (JMP_SQUASH)
  ) u_stall_ctrl (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_mul_op      (w_mul_op),
    .i_jmp_taken   (w_jmp_taken),
    .o_stall       (w_stall),
    .o_final_cycle (w_final),
    .o_squash_next (w_squash_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir     <= 8'h00;
      r_bubble <= 1'b1;
    end else if (!w_stall) begin
      r_ir     <= next_instr;
      r_bubble <= ~instr_valid | w_squash_next;
    end
  end

  always_comb begin
    w_en   = '0;
    w_src  = 4'd0;
    w_isel = 1'b1;
    w_x    = 1'b0;
    w_y    = 1'b0;
    w_jmp  = 1'b0;
    w_jnz  = 1'b0;
    case (w_type)
      LOAD: begin
        w_src  = SRC_LOAD;
        w_en   = dst_enable(w_ld_dst);
        w_isel = (w_ld_dst != C_DST_I);
        if (w_ld_dst == C_DST_DM) w_en[C_EN_I] = 1'b1;
      end
      MOVE: begin
        w_src  = {1'b0, w_mv_src};
        w_isel = (w_mv_dst != C_DST_I);
        if ((w_mv_dst == C_DST_OREG) && (w_mv_src == C_SRC_R)) begin
          w_en[C_EN_OREG] = 1'b1;
        end else begin
          w_en = dst_enable(w_mv_dst);
          // Any dm access post-increments i, unless i itself is being written.
          if ((w_mv_dst == C_DST_DM) || ((w_mv_src == C_DST_DM) && (w_mv_dst != C_DST_I)))
            w_en[C_EN_I] = 1'b1;
        end
      end
      ALU: begin
        w_x          = r_ir[4];
        w_y          = r_ir[3];
        w_en[C_EN_R] = w_final;
      end
      JUMP:             w_jmp = 1'b1;
      CONDITIONAL_JUMP: w_jnz = 1'b1;
      default: ;
    endcase
    if (r_bubble) begin
      w_en  = '0;
      w_jmp = 1'b0;
      w_jnz = 1'b0;
    end
  end

  assign w_jmp_taken = w_jmp | (w_jnz & ~zero_flag);

  always_comb begin
    if (!reset_n) begin
      ir         = 8'h00;
      ir_nibble  = 4'h0;
      jmp        = 1'b0;
      jmp_nz     = 1'b0;
      jmp_taken  = 1'b0;
      i_sel      = 1'b0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      source_sel = SRC_RESET;
      reg_en     = '1;
      stall      = 1'b0;
    end else begin
      ir         = r_ir;
      ir_nibble  = r_ir[3:0];
      jmp        = w_jmp;
      jmp_nz     = w_jnz;
      jmp_taken  = w_jmp_taken;
      i_sel      = w_isel;
      x_sel      = w_x;
      y_sel      = w_y;
      source_sel = w_src;
      reg_en     = w_en;
      stall      = w_stall;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
// tb_pipelined_instruction_decoder: directed per-cycle vectors checked by a queue-based monitor
// Rev 1.0
`default_nettype none
module tb_pipelined_instruction_decoder;

  logic       clk = 1'b1;
  logic       reset_n;
  logic [7:0] next_instr;
  logic       instr_valid;
  logic       zero_flag;
  logic [7:0] ir;
  logic [3:0] ir_nibble;
  logic       jmp, jmp_nz, jmp_taken, i_sel, x_sel, y_sel, stall;
  logic [3:0] source_sel;
  logic [8:0] reg_en;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      nm;
    logic [7:0] ir;
    logic [8:0] en;
    logic [3:0] src;
    logic       stall;
    logic [2:0] j;    // jmp, jmp_nz, jmp_taken
    logic [2:0] sel;  // i_sel, x_sel, y_sel
    logic       chk_sel;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_instruction_decoder #(
    .MUL_LAT    (3),
    .JMP_SQUASH (1),
    .NUM_EN     (9)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .next_instr  (next_instr),
    .instr_valid (instr_valid),
    .zero_flag   (zero_flag),
    .ir          (ir),
    .ir_nibble   (ir_nibble),
    .jmp         (jmp),
    .jmp_nz      (jmp_nz),
    .jmp_taken   (jmp_taken),
    .i_sel       (i_sel),
    .x_sel       (x_sel),
    .y_sel       (y_sel),
    .source_sel  (source_sel),
    .reg_en      (reg_en),
    .stall       (stall)
  );

  task automatic chk(input string nm, input string fld, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "ir",        {1'b0, ir},          {1'b0, e.ir});
      chk(e.nm, "ir_nibble", {5'b0, ir_nibble},   {5'b0, e.ir[3:0]});
      chk(e.nm, "reg_en",    reg_en,              e.en);
      chk(e.nm, "stall",     {8'b0, stall},       {8'b0, e.stall});
      chk(e.nm, "jmp",       {8'b0, jmp},         {8'b0, e.j[2]});
      chk(e.nm, "jmp_nz",    {8'b0, jmp_nz},      {8'b0, e.j[1]});
      chk(e.nm, "jmp_taken", {8'b0, jmp_taken},   {8'b0, e.j[0]});
      if (e.chk_sel) begin
        chk(e.nm, "source_sel", {5'b0, source_sel}, {5'b0, e.src});
        chk(e.nm, "i_sel",      {8'b0, i_sel},      {8'b0, e.sel[2]});
        chk(e.nm, "x_sel",      {8'b0, x_sel},      {8'b0, e.sel[1]});
        chk(e.nm, "y_sel",      {8'b0, y_sel},      {8'b0, e.sel[0]});
      end
    end
  end

  // Drive this cycle's inputs, queue the outputs expected during this cycle, advance one edge.
  task automatic cyc(input logic rn, input logic [7:0] ni, input logic iv, input logic zf,
                     input string nm, input logic [7:0] e_ir, input logic [8:0] e_en,
                     input logic [3:0] e_src, input logic e_stall, input logic [2:0] e_j,
                     input logic [2:0] e_sel, input logic chk_sel);
    exp_t e;
    reset_n     = rn;
    next_instr  = ni;
    instr_valid = iv;
    zero_flag   = zf;
    e.nm = nm; e.ir = e_ir; e.en = e_en; e.src = e_src; e.stall = e_stall;
    e.j = e_j; e.sel = e_sel; e.chk_sel = chk_sel;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  rn  ni     iv zf  name       ir     reg_en  src   stl j       sel     chk
    cyc(0, 8'h35, 1, 0, "reset",    8'h00, 9'h1ff, 4'hA, 0, 3'b000, 3'b000, 1);
    cyc(1, 8'h35, 1, 0, "post_rst", 8'h00, 9'h000, 4'h0, 0, 3'b000, 3'b000, 0);
    cyc(1, 8'hA4, 1, 0, "ld35",     8'h35, 9'h008, 4'h8, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'hBF, 1, 0, "mvA4",     8'hA4, 9'h100, 4'h4, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'h72, 1, 0, "mvBF",     8'hBF, 9'h0C0, 4'h7, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'h61, 1, 0, "ld72",     8'h72, 9'h0C0, 4'h8, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'h87, 1, 0, "ld61",     8'h61, 9'h040, 4'h8, 0, 3'b000, 3'b000, 1);
    cyc(1, 8'hB7, 1, 0, "mv87",     8'h87, 9'h041, 4'h7, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'hC9, 1, 0, "mvB7",     8'hB7, 9'h040, 4'h7, 0, 3'b000, 3'b000, 1);
    cyc(1, 8'hD7, 1, 0, "aluC9",    8'hC9, 9'h010, 4'h0, 0, 3'b000, 3'b101, 1);
    cyc(1, 8'h35, 1, 0, "mul0",     8'hD7, 9'h000, 4'h0, 1, 3'b000, 3'b110, 1);
    cyc(1, 8'h35, 1, 0, "mul1",     8'hD7, 9'h000, 4'h0, 1, 3'b000, 3'b110, 1);
    cyc(1, 8'h35, 1, 0, "mul2",     8'hD7, 9'h010, 4'h0, 0, 3'b000, 3'b110, 1);
    cyc(1, 8'hF6, 1, 0, "ld35b",    8'h35, 9'h008, 4'h8, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'h12, 1, 0, "jnz_t",    8'hF6, 9'h000, 4'h0, 0, 3'b011, 3'b100, 1);
    cyc(1, 8'hA4, 1, 0, "sq_bub",   8'h12, 9'h000, 4'h0, 0, 3'b000, 3'b000, 0);
    cyc(1, 8'hF6, 1, 0, "mvA4b",    8'hA4, 9'h100, 4'h4, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'h12, 1, 1, "jnz_nt",   8'hF6, 9'h000, 4'h0, 0, 3'b010, 3'b100, 1);
    cyc(1, 8'hE3, 0, 0, "ld12",     8'h12, 9'h002, 4'h8, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'hE5, 1, 0, "inv_bub",  8'hE3, 9'h000, 4'h0, 0, 3'b000, 3'b000, 0);
    cyc(1, 8'hE3, 1, 0, "jmp",      8'hE5, 9'h000, 4'h0, 0, 3'b101, 3'b100, 1);
    cyc(1, 8'h35, 1, 0, "sq_jmp",   8'hE3, 9'h000, 4'h0, 0, 3'b000, 3'b000, 0);
    cyc(1, 8'hD7, 1, 0, "ld35c",    8'h35, 9'h008, 4'h8, 0, 3'b000, 3'b100, 1);
    cyc(1, 8'hA4, 1, 0, "mulr0",    8'hD7, 9'h000, 4'h0, 1, 3'b000, 3'b110, 1);
    cyc(1, 8'hA4, 1, 0, "mulr1",    8'hD7, 9'h000, 4'h0, 1, 3'b000, 3'b110, 1);
    cyc(0, 8'hA4, 1, 0, "rst_mul",  8'h00, 9'h1ff, 4'hA, 0, 3'b000, 3'b000, 1);
    cyc(1, 8'hA4, 1, 0, "rel",      8'h00, 9'h000, 4'h0, 0, 3'b000, 3'b000, 0);
    cyc(1, 8'h35, 1, 0, "after",    8'hA4, 9'h100, 4'h4, 0, 3'b000, 3'b100, 1);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
